// File: rtl/fpa_add.sv
// fpa_add: registered adder for sign/magnitude floats (explicit leading one, two's complement exponent)
module fpa_add (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        out_valid,
  output logic [31:0] out
);
  logic               swap, same, a_ge, carry, sgn;
  logic [31:0]        a, b, res;
  logic signed [9:0]  ea, eb, e1, en;
  logic [9:0]         d;
  logic [22:0]        ma, mb, mb_al, dif, mag, norm;
  logic [23:0]        sum;
  logic [4:0]         lz;
  always_comb begin
    swap  = $signed(in2[30:23]) > $signed(in1[30:23]);
    a     = swap ? in2 : in1;
    b     = swap ? in1 : in2;
    ea    = {{2{a[30]}}, a[30:23]};
    eb    = {{2{b[30]}}, b[30:23]};
    ma    = a[22:0];
    mb    = b[22:0];
    d     = ea - eb;
    mb_al = d < 10'd24 ? mb >> d : 23'd0;
    same  = a[31] == b[31];
    sum   = {1'b0, ma} + {1'b0, mb_al};
    a_ge  = ma >= mb_al;
    dif   = a_ge ? ma - mb_al : mb_al - ma;
    sgn   = (same || a_ge) ? a[31] : b[31];
    carry = same & sum[23];
    mag   = same ? (carry ? sum[23:1] : sum[22:0]) : dif;
    e1    = ea + {9'd0, carry};
  end
  // highest set bit wins, so lz ends as the distance from bit 22
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 23; i++) if (mag[i]) lz = 5'(22 - i);
  end
  always_comb begin
    norm = mag << lz;
    en   = e1 - {5'd0, lz};
    res  = in1[22:0] == 23'd0 ? (in2[22:0] == 23'd0 ? 32'h0 : in2) :
           in2[22:0] == 23'd0 ? in1 :
           mag == 23'd0       ? 32'h0 :
           en > 10'sd127      ? {sgn, 8'h7f, 23'h7fffff} :
           en < -10'sd128     ? 32'h0 :
                                {sgn, en[7:0], norm};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out       <= 32'h0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= res;
    end
endmodule

// File: tb/tb_fpa_add.sv
// tb_fpa_add: directed vectors, expected values queued by the driver and checked by an output monitor
module tb_fpa_add;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [31:0] in1 = 32'h0, in2 = 32'h0, out;
  logic        out_valid;
  logic [31:0] q[$];
  logic [31:0] last;
  int          n_chk = 0, n_fail = 0;

  fpa_add dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in1(in1), .in2(in2),
               .out_valid(out_valid), .out(out));

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && out_valid) begin
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL spurious_valid: out_valid=1 out=%h, required no result", out);
    end else begin
      last = q.pop_front();
      if (out !== last) begin
        n_fail++;
        $display("FAIL result: out=%h required=%h", out, last);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    in_valid = 1'b1;
    in1 = a;
    in2 = b;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_out", out, 32'h0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send(32'h01CE0000, 32'h024A4000, 32'h02714000);
    send(32'h01CE0000, 32'h824A4000, 32'h81C68000);
    send(32'h81CE0000, 32'h024A4000, 32'h01C68000);
    send(32'h81CE0000, 32'h824A4000, 32'h82714000);
    send(32'h01FFFFFF, 32'h01FFFFFF, 32'h027FFFFF);
    send(32'h81FFFFFF, 32'h81FFFFFF, 32'h827FFFFF);
    send(32'h01540000, 32'h00600000, 32'h016C0000);
    send(32'h01C90000, 32'h817A0000, 32'h00600000);
    send(32'h00000000, 32'h00000000, 32'h00000000);
    send(32'h01CE0000, 32'h81CE0000, 32'h00000000);
    send(32'h00000000, 32'h824A4000, 32'h824A4000);
    send(32'h01540000, 32'h7F800000, 32'h01540000);
    send(32'h00600000, 32'h0F400000, 32'h0F400000);
    send(32'h7FC00000, 32'h7FC00000, 32'h00400000);
    send(32'h3FC00000, 32'h3FC00000, 32'h3FFFFFFF);
    send(32'hBFC00000, 32'hBFC00000, 32'hBFFFFFFF);
    send(32'h40700000, 32'hC0600000, 32'h00000000);
    send(32'h01540000, 32'h01540000, 32'h01D40000);
    repeat (3) @(negedge clk);
    check("hold_out", out, 32'h01D40000);
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    send(32'h01CE0000, 32'h024A4000, 32'h02714000);
    #2 rst = 1'b1;
    #1;
    check("async_reset_out", out, 32'h0);
    check("async_reset_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(32'h01540000, 32'h00600000, 32'h016C0000);
    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
